// File: rtl/sensor_packet_pkg.sv
// Shared framing constants, state and error encodings for the sensor packetiser/parser pair.
// Word layout of a pixel beat: {reserved[31:22], index[21:12], pixel[11:0]}.
package sensor_packet_pkg;

  localparam logic [31:0] HEADER_VALUE = 32'hAAAAAAAA;
  localparam logic [31:0] FOOTER_VALUE = 32'h55555555;

  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_TIME_STAMP = 4'd1;
  localparam logic [3:0] ST_DATA       = 4'd2;
  localparam logic [3:0] ST_FOOTER     = 4'd3;
  localparam logic [3:0] ST_RESYNC     = 4'd4;

  typedef enum logic [3:0] {
    IDLE       = ST_IDLE,
    TIME_STAMP = ST_TIME_STAMP,
    DATA       = ST_DATA,
    FOOTER     = ST_FOOTER,
    RESYNC     = ST_RESYNC
  } parser_state_t;

  typedef enum logic [2:0] {
    ERR_NONE   = 3'd0,
    ERR_TLAST  = 3'd1,
    ERR_SEQ    = 3'd2,
    ERR_RSVD   = 3'd3,
    ERR_FOOTER = 3'd4
  } err_code_t;

  localparam int IDX_MSB  = 21;
  localparam int IDX_LSB  = 12;
  localparam int PIX_MSB  = 11;
  localparam int PIX_LSB  = 0;
  localparam int RSVD_LSB = 22;

endpackage

// File: rtl/sensor_packet_parser_if.sv
// AXI-Stream link from the sensor packetiser into the parser.
interface sensor_packet_parser_if;

  // A beat transfers on a rising clock edge where s_tvalid && s_tready; the
  // source holds s_tdata/s_tlast stable while s_tvalid is high and not accepted.
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;

  modport master (output s_tdata, output s_tvalid, output s_tlast, input s_tready);
  modport slave  (input s_tdata, input s_tvalid, input s_tlast, output s_tready);

endinterface

// File: rtl/sensor_packet_parser_sat_counter16.sv
// 16-bit event counter with synchronous clear that sticks at 16'hFFFF.
module sat_counter16 (
    input  logic        master_clock,
    input  logic        clear,
    input  logic        enable,
    output logic [15:0] count
);

    always_ff @(posedge master_clock) begin
        if (clear) begin
            count <= 16'd0;
        end else if (enable && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/sensor_packet_parser.sv
// Parses header/timestamp/pixel/footer frames from an AXI-Stream link, emits pixels
// one cycle after their beat and reports good or aborted frames with one-cycle pulses.
module sensor_packet_parser
    import sensor_packet_pkg::*;
#(
    parameter int          NUM_PIXELS   = 1024,
    parameter logic [31:0] HEADER_VALUE = sensor_packet_pkg::HEADER_VALUE,
    parameter logic [31:0] FOOTER_VALUE = sensor_packet_pkg::FOOTER_VALUE
) (
    input  logic                        master_clock,
    input  logic                        resetn,
    sensor_packet_parser_if.slave       axis,
    output logic [11:0]                 pix_data,
    output logic [9:0]                  pix_index,
    output logic                        pix_valid,
    output logic [31:0]                 frame_timestamp,
    output logic                        frame_done,
    output logic                        frame_error,
    output logic [2:0]                  err_code,
    output logic [15:0]                 frame_count,
    output logic [15:0]                 error_count,
    output logic [3:0]                  dbg_state
);

    localparam logic [9:0] LAST_INDEX = 10'(NUM_PIXELS - 1);

    parser_state_t state_q, state_d;
    logic          tready_q;
    logic          beat;
    logic [9:0]    exp_idx_q;
    logic [31:0]   ts_shadow_q;
    logic [9:0]    word_idx;
    logic          rsvd_set;

    logic          pix_fire, done_fire, err_fire, ts_load;
    err_code_t     err_d;
    logic          cnt_clear;

    assign axis.s_tready = tready_q;
    assign beat          = axis.s_tvalid && tready_q;
    assign word_idx      = axis.s_tdata[IDX_MSB:IDX_LSB];
    assign rsvd_set      = |axis.s_tdata[31:RSVD_LSB];
    assign cnt_clear     = ~resetn;

    always_ff @(posedge master_clock) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pix_fire  = 1'b0;
        done_fire = 1'b0;
        err_fire  = 1'b0;
        ts_load   = 1'b0;
        err_d     = ERR_NONE;
        if (beat) begin
            case (state_q)
                IDLE: begin
                    // Anything but a clean header is line noise between frames.
                    if ((axis.s_tdata == HEADER_VALUE) && !axis.s_tlast) begin
                        state_d = TIME_STAMP;
                    end
                end
                TIME_STAMP: begin
                    if (axis.s_tlast) begin
                        err_fire = 1'b1;
                        err_d    = ERR_TLAST;
                        state_d  = IDLE;
                    end else begin
                        ts_load = 1'b1;
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (axis.s_tlast) begin
                        err_fire = 1'b1;
                        err_d    = ERR_TLAST;
                        state_d  = IDLE;
                    end else if (rsvd_set) begin
                        err_fire = 1'b1;
                        err_d    = ERR_RSVD;
                        state_d  = RESYNC;
                    end else if (word_idx != exp_idx_q) begin
                        err_fire = 1'b1;
                        err_d    = ERR_SEQ;
                        state_d  = RESYNC;
                    end else begin
                        pix_fire = 1'b1;
                        if (word_idx == LAST_INDEX) begin
                            state_d = FOOTER;
                        end
                    end
                end
                FOOTER: begin
                    if ((axis.s_tdata == FOOTER_VALUE) && axis.s_tlast) begin
                        done_fire = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        err_fire = 1'b1;
                        err_d    = ERR_FOOTER;
                        state_d  = axis.s_tlast ? IDLE : RESYNC;
                    end
                end
                RESYNC: begin
                    if (axis.s_tlast) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge master_clock) begin
        if (!resetn) begin
            tready_q        <= 1'b0;
            dbg_state       <= 4'd0;
            exp_idx_q       <= 10'd0;
            ts_shadow_q     <= 32'd0;
            pix_data        <= 12'd0;
            pix_index       <= 10'd0;
            pix_valid       <= 1'b0;
            frame_timestamp <= 32'd0;
            frame_done      <= 1'b0;
            frame_error     <= 1'b0;
            err_code        <= 3'd0;
        end else begin
            tready_q    <= 1'b1;
            dbg_state   <= state_q;
            pix_valid   <= pix_fire;
            frame_done  <= done_fire;
            frame_error <= err_fire;
            if (ts_load) begin
                ts_shadow_q <= axis.s_tdata;
                exp_idx_q   <= 10'd0;
            end else if (pix_fire) begin
                // Wraps to 0 only after the last index, where the frame leaves DATA.
                exp_idx_q <= exp_idx_q + 10'd1;
            end
            if (pix_fire) begin
                pix_data  <= axis.s_tdata[PIX_MSB:PIX_LSB];
                pix_index <= word_idx;
            end
            if (done_fire) begin
                frame_timestamp <= ts_shadow_q;
            end
            if (err_fire) begin
                err_code <= err_d;
            end
        end
    end

    sat_counter16 u_frame_count (
        .master_clock (master_clock),
        .clear        (cnt_clear),
        .enable       (done_fire),
        .count        (frame_count)
    );

    sat_counter16 u_error_count (
        .master_clock (master_clock),
        .clear        (cnt_clear),
        .enable       (err_fire),
        .count        (error_count)
    );

endmodule

// File: tb/tb_sensor_packet_parser.sv
// Directed scoreboard bench for sensor_packet_parser: drivers push expected pixels and
// frame events into queues, a negedge monitor pops and compares whenever the DUT strobes.
module tb_sensor_packet_parser;
    import sensor_packet_pkg::*;

    localparam logic [3:0] EV_NONE = 4'hF;
    localparam logic [3:0] EV_DONE = 4'h8;

    logic master_clock = 1'b0;
    logic resetn = 1'b0;
    always #5 master_clock = ~master_clock;

    sensor_packet_parser_if axis();

    logic [11:0] pix_data;
    logic [9:0]  pix_index;
    logic        pix_valid;
    logic [31:0] frame_timestamp;
    logic        frame_done;
    logic        frame_error;
    logic [2:0]  err_code;
    logic [15:0] frame_count;
    logic [15:0] error_count;
    logic [3:0]  dbg_state;

    sensor_packet_parser dut (
        .master_clock    (master_clock),
        .resetn          (resetn),
        .axis            (axis),
        .pix_data        (pix_data),
        .pix_index       (pix_index),
        .pix_valid       (pix_valid),
        .frame_timestamp (frame_timestamp),
        .frame_done      (frame_done),
        .frame_error     (frame_error),
        .err_code        (err_code),
        .frame_count     (frame_count),
        .error_count     (error_count),
        .dbg_state       (dbg_state)
    );

    int cyc = 0;
    always @(posedge master_clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;
    logic [21:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [3:0]  ev_q[$];
    int          ev_cyc_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe from the DUT must match the head of its queue, in the cycle predicted.
    always @(negedge master_clock) begin : monitor
        logic [21:0] e;
        logic [3:0]  ev;
        logic [3:0]  ev_exp;
        int          c;
        if (pix_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pix_unexpected: got idx %0d data %h with nothing queued", pix_index, pix_data);
            end else begin
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                check("pix_word", 32'({pix_index, pix_data}), 32'(e));
                check("pix_latency", cyc, c);
            end
        end
        if (frame_done || frame_error) begin
            ev = frame_done ? EV_DONE : {1'b0, err_code};
            if (ev_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL event_unexpected: got %h with nothing queued", ev);
            end else begin
                ev_exp = ev_q.pop_front();
                c = ev_cyc_q.pop_front();
                check("frame_event", 32'(ev), 32'(ev_exp));
                check("event_latency", cyc, c);
            end
        end
        if (frame_done && frame_error) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_and_error: both pulses high together");
        end
    end

    function automatic logic [31:0] pix_word(input int idx);
        logic [9:0] i;
        i = idx[9:0];
        return {10'd0, i, 12'(i) ^ 12'hABC};
    endfunction

    task automatic send_beat(input logic [31:0] d, input logic l, input int gap,
                             input bit exp_pix, input logic [3:0] exp_ev);
        int n;
        n = 0;
        axis.s_tvalid = 1'b0;
        repeat (gap) begin
            @(posedge master_clock);
            #1;
        end
        axis.s_tdata  = d;
        axis.s_tlast  = l;
        axis.s_tvalid = 1'b1;
        while (!axis.s_tready && n < 50) begin
            @(posedge master_clock);
            #1;
            n++;
        end
        if (!axis.s_tready) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: s_tready got %b expected 1", axis.s_tready);
        end
        @(posedge master_clock);
        #1;
        if (exp_pix) begin
            exp_q.push_back(d[21:0]);
            exp_cyc_q.push_back(cyc);
        end
        if (exp_ev != EV_NONE) begin
            ev_q.push_back(exp_ev);
            ev_cyc_q.push_back(cyc);
        end
        axis.s_tvalid = 1'b0;
    endtask

    task automatic send_prefix(input logic [31:0] ts, input int n_pix, input int max_gap);
        send_beat(HEADER_VALUE, 1'b0, int'($urandom_range(max_gap, 0)), 1'b0, EV_NONE);
        send_beat(ts, 1'b0, int'($urandom_range(max_gap, 0)), 1'b0, EV_NONE);
        for (int i = 0; i < n_pix; i++) begin
            send_beat(pix_word(i), 1'b0, int'($urandom_range(max_gap, 0)), 1'b1, EV_NONE);
        end
    endtask

    task automatic send_frame(input logic [31:0] ts, input int max_gap);
        send_prefix(ts, 1024, max_gap);
        send_beat(FOOTER_VALUE, 1'b1, int'($urandom_range(max_gap, 0)), 1'b0, EV_DONE);
    endtask

    task automatic drain();
        axis.s_tvalid = 1'b0;
        repeat (3) @(posedge master_clock);
        #1;
        check("pix_queue_empty", exp_q.size(), 0);
        check("event_queue_empty", ev_q.size(), 0);
    endtask

    task automatic check_status(input logic [15:0] fc, input logic [15:0] ec,
                                input logic [31:0] ts, input logic [2:0] code, input logic [3:0] st);
        check("frame_count", 32'(frame_count), 32'(fc));
        check("error_count", 32'(error_count), 32'(ec));
        check("frame_timestamp", frame_timestamp, ts);
        check("err_code", 32'(err_code), 32'(code));
        check("dbg_state", 32'(dbg_state), 32'(st));
    endtask

    task automatic do_reset();
        axis.s_tvalid = 1'b0;
        axis.s_tlast  = 1'b0;
        axis.s_tdata  = 32'd0;
        resetn = 1'b0;
        repeat (3) @(posedge master_clock);
        #1;
        check("rst_s_tready", 32'(axis.s_tready), 32'd0);
        check("rst_strobes", 32'({pix_valid, frame_done, frame_error}), 32'd0);
        check("rst_pix", 32'({pix_index, pix_data}), 32'd0);
        check_status(16'd0, 16'd0, 32'd0, 3'd0, 4'd0);
        resetn = 1'b1;
        @(posedge master_clock);
        #1;
        check("ready_after_reset", 32'(axis.s_tready), 32'd1);
    endtask

    initial begin : watchdog
        #2000000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : stimulus
        do_reset();

        // Good frame, no gaps.
        send_frame(32'h12345678, 0);
        drain();
        check_status(16'd1, 16'd0, 32'h12345678, 3'd0, 4'd0);

        // Gapped frame followed back-to-back by a second frame.
        do_reset();
        send_frame(32'h12345678, 5);
        check("frame_count_after_gapped", 32'(frame_count), 32'd1);
        send_frame(32'h0BADF00D, 0);
        drain();
        check_status(16'd2, 16'd0, 32'h0BADF00D, 3'd0, 4'd0);

        // Index skip: 0..9 then 11 -> sequence error, resync to tlast, then a good frame.
        do_reset();
        send_prefix(32'h11111111, 10, 0);
        send_beat(pix_word(11), 1'b0, 0, 1'b0, {1'b0, ERR_SEQ});
        @(posedge master_clock);
        #1;
        check("state_resync", 32'(dbg_state), 32'(ST_RESYNC));
        for (int i = 12; i < 20; i++) send_beat(pix_word(i), 1'b0, 0, 1'b0, EV_NONE);
        send_beat(pix_word(20), 1'b1, 0, 1'b0, EV_NONE);
        send_frame(32'h22222222, 0);
        drain();
        check_status(16'd1, 16'd1, 32'h22222222, 3'd2, 4'd0);

        // Early tlast on index 500.
        send_prefix(32'hCAFEF00D, 500, 0);
        send_beat(pix_word(500), 1'b1, 0, 1'b0, {1'b0, ERR_TLAST});
        drain();
        check_status(16'd1, 16'd2, 32'h22222222, 3'd1, 4'd0);

        // Bad footer carrying tlast.
        send_prefix(32'h33333333, 1024, 0);
        send_beat(32'h55555554, 1'b1, 0, 1'b0, {1'b0, ERR_FOOTER});
        drain();
        check_status(16'd1, 16'd3, 32'h22222222, 3'd4, 4'd0);

        // Reserved bit set on index 5 (index field also wrong; reserved wins).
        send_prefix(32'h44444444, 5, 0);
        send_beat(32'h00400000 | 32'd5, 1'b0, 0, 1'b0, {1'b0, ERR_RSVD});
        send_beat(pix_word(6), 1'b1, 0, 1'b0, EV_NONE);
        drain();
        check_status(16'd1, 16'd4, 32'h22222222, 3'd3, 4'd0);

        // Garbage and a header with tlast ahead of a real frame are ignored.
        send_beat(32'hDEADBEEF, 1'b0, 0, 1'b0, EV_NONE);
        send_beat(32'hDEADBEEF, 1'b1, 0, 1'b0, EV_NONE);
        send_beat(HEADER_VALUE, 1'b1, 0, 1'b0, EV_NONE);
        drain();
        check_status(16'd1, 16'd4, 32'h22222222, 3'd3, 4'd0);
        send_frame(32'h55AA55AA, 0);
        drain();
        check_status(16'd2, 16'd4, 32'h55AA55AA, 3'd3, 4'd0);

        // Reset at index 300 discards the partial frame silently.
        send_prefix(32'h66666666, 300, 0);
        drain();
        do_reset();
        send_frame(32'h77777777, 0);
        drain();
        check_status(16'd1, 16'd0, 32'h77777777, 3'd0, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sensor_packet_parser.md
Name: sensor_packet_parser

Overview:
- AXI-Stream slave that receives frames built by the sensor acquisition packetiser and recovers the pixel data.
- Frame layout: header 0xAAAAAAAA, 32-bit timestamp, NUM_PIXELS words {10'd0, index[9:0], pixel[11:0]}, footer 0x55555555 with tlast.
- Validates framing, index sequence and reserved bits, then emits a pixel stream and a per-frame timestamp.
- Sits on the PS/loopback side of the sensor datapath.

Parameters:
- NUM_PIXELS, 1024, data words per frame; last index is NUM_PIXELS-1.
- HEADER_VALUE, 32'hAAAAAAAA, frame start marker.
- FOOTER_VALUE, 32'h55555555, frame end marker.

Ports:
- master_clock  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- s_tdata  in  32  AXIS data.
- s_tvalid  in  1  AXIS valid.
- s_tlast  in  1  AXIS last.
- s_tready  out  1  AXIS ready.
- pix_data  out  12  recovered pixel.
- pix_index  out  10  recovered index.
- pix_valid  out  1  pixel strobe.
- frame_timestamp  out  32  timestamp of the last good frame.
- frame_done  out  1  one-cycle pulse, good frame received.
- frame_error  out  1  one-cycle pulse, frame aborted.
- err_code  out  3  cause of the last error.
- frame_count  out  16  good frames, saturating.
- error_count  out  16  aborted frames, saturating.
- dbg_state  out  4  current state.

Behaviour:
- Reset value of all outputs is 0, and state is IDLE. Reset mid-frame discards the partial frame with no error pulse.
- s_tready is a register: 0 in reset, 1 from the first cycle after resetn rises. A beat is accepted when s_tvalid && s_tready.
- Gaps in s_tvalid hold state indefinitely; there is no timeout.
- State encoding: IDLE=0, TIME_STAMP=1, DATA=2, FOOTER=3, RESYNC=4.
- IDLE:
  - Accepted beat == HEADER_VALUE with tlast=0 -> TIME_STAMP.
  - Any other beat, including a header carrying tlast, is silently dropped; stay in IDLE.
- TIME_STAMP:
  - Beat is latched to ts_shadow and expected index is cleared to 0 -> DATA.
  - If tlast=1: error code 1 (early tlast) -> IDLE.
- DATA, checks are applied in priority order:
  1. tlast=1 -> error 1 -> IDLE.
  2. tdata[31:22] != 0 -> error 3 (reserved bits) -> RESYNC.
  3. tdata[21:12] != expected -> error 2 (sequence) -> RESYNC.
  4. Otherwise register pix_data=tdata[11:0], pix_index=tdata[21:12], pix_valid=1 on the next cycle (latency 1) and increment expected. If index == NUM_PIXELS-1 -> FOOTER.
- FOOTER:
  - Beat == FOOTER_VALUE with tlast=1: next cycle frame_done=1, frame_timestamp<=ts_shadow, frame_count++ -> IDLE.
  - Otherwise error 4 (bad footer). Go to IDLE if tlast=1, else RESYNC.
- RESYNC: drop beats until an accepted beat with tlast=1 -> IDLE. No further error is raised.
- Error action:
  - frame_error pulses one cycle after the offending beat.
  - err_code is updated at the same time and held until the next error.
  - error_count++.
  - Pixels already emitted are not retracted; downstream qualifies them with frame_error.
- Counters saturate at 16'hFFFF with no wrap. The expected-index counter is 10 bits and never wraps within a frame, because FOOTER is entered at NUM_PIXELS-1.
- frame_timestamp changes only on good frames. frame_done and frame_error are never asserted in the same cycle.
- dbg_state is a registered copy of the state, one cycle late.

Decomposition:
- Package sensor_packet_pkg, shared with the packetiser:
  - HEADER_VALUE and FOOTER_VALUE.
  - State localparams.
  - Error codes ERR_NONE=0, ERR_TLAST=1, ERR_SEQ=2, ERR_RSVD=3, ERR_FOOTER=4.
  - Word field positions: index [21:12], pixel [11:0].
- One sub-module, sat_counter16 (enable, synchronous clear, saturate), instantiated for frame_count and error_count.

Test Plan:
- Good frame: header, ts=0x12345678, indices 0..1023 with pixel=index^0xABC, footer+tlast.
  -> 1024 pix_valid pulses with matching data, each 1 cycle after its beat.
  -> frame_done=1 once; frame_timestamp=0x12345678; frame_count=1.
- Same good frame with random tvalid gaps (0-5 idle cycles), then back-to-back frames with no gap.
  -> identical outputs; frame_count=2 after the second frame.
- Index skip: indices 0..9, then 11.
  -> 10 pixels emitted; frame_error pulse; err_code=2; parser enters RESYNC.
  -> Beats up to tlast are dropped; the next good frame is accepted (frame_count=1, error_count=1).
- Early tlast on index 500.
  -> err_code=1, state IDLE on the next beat; frame_timestamp unchanged.
- Bad footer 0x55555554 with tlast -> err_code=4, no frame_done. Separately, word 0x00400000|idx (reserved bit set) -> err_code=3.
- Garbage 0xDEADBEEF beats before a header -> ignored, with no error and no count change.
- resetn low at index 300 -> all outputs 0 and s_tready=0 during reset. After release, a full frame parses cleanly.
